// File: rtl/control_sequencer.sv
// SAP-2 microcoded control sequencer: fetch/decode/execute T-states and datapath strobes.
// Build option: define CONTROL_ILLEGAL_TRAP_EN to trap unassigned opcodes (9-D) into HALT.
module control_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       flag_zero,
    input  logic       flag_carry,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       pc_oe,
    output logic       mar_load,
    output logic       ram_oe,
    output logic       ram_we,
    output logic       ir_load,
    output logic       ir_oe,
    output logic       a_load,
    output logic       a_oe,
    output logic       b_load,
    output logic       alu_sub,
    output logic       alu_oe,
    output logic       out_load,
    output logic       halt,
    output logic       illegal,
    output logic [3:0] t_step
);

    localparam int unsigned OPCODE_WIDTH = 4;
    localparam int unsigned FETCH_STEPS  = 5;
    localparam int unsigned T_WIDTH      = 4;

    localparam logic [OPCODE_WIDTH-1:0] OP_NOP = 4'h0;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDA = 4'h1;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 4'h2;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB = 4'h3;
    localparam logic [OPCODE_WIDTH-1:0] OP_STA = 4'h4;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI = 4'h5;
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 4'h6;
    localparam logic [OPCODE_WIDTH-1:0] OP_JC  = 4'h7;
    localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = 4'h8;
    localparam logic [OPCODE_WIDTH-1:0] OP_OUT = 4'hE;
    localparam logic [OPCODE_WIDTH-1:0] OP_HLT = 4'hF;

`ifdef CONTROL_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_F0   = 4'd0,
        S_F1   = 4'd1,
        S_F2   = 4'd2,
        S_F3   = 4'd3,
        S_F4   = 4'd4,
        S_E0   = 4'd5,
        S_E1   = 4'd6,
        S_E2   = 4'd7,
        S_E3   = 4'd8,
        S_E4   = 4'd9,
        S_HALT = 4'd10
    } state_t;

    state_t                  state_q, state_d;
    state_t                  exec_last;
    logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
    logic [T_WIDTH-1:0]      t_step_q, t_step_d;
    logic                    illegal_q, illegal_d;
    logic                    unassigned;

    assign unassigned = opcode_q inside {[4'h9:4'hD]};

    // Final execute state per opcode; that state is always idle and returns to F0.
    always_comb begin
        exec_last = S_E0;
        case (opcode_q)
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT: exec_last = S_E1;
            OP_LDA, OP_STA:                       exec_last = S_E3;
            OP_ADD, OP_SUB:                       exec_last = S_E4;
            default:                              exec_last = S_E0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        illegal_d = illegal_q;
        case (state_q)
            S_F0: state_d = S_F1;
            S_F1: state_d = S_F2;
            S_F2: state_d = S_F3;
            S_F3: begin
                state_d  = S_F4;
                opcode_d = opcode;
            end
            S_F4: begin
                if (opcode_q == OP_HLT) begin
                    state_d = S_HALT;
                end else if (TRAP_EN && unassigned) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_E0;
                end
            end
            S_E0, S_E1, S_E2, S_E3, S_E4: begin
                state_d = (state_q == exec_last) ? S_F0 : state_t'(state_q + 4'd1);
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_F0;
        endcase
        if (state_d == S_F0) begin
            t_step_d = '0;
        end else if (t_step_q == T_WIDTH'(15)) begin
            t_step_d = t_step_q;
        end else begin
            t_step_d = t_step_q + T_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_F0;
            opcode_q  <= OP_NOP;
            t_step_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            t_step_q  <= t_step_d;
            illegal_q <= illegal_d;
        end
    end

    // Microcode ROM: strobes from registered state and latched opcode, forced quiet in reset.
    always_comb begin
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        pc_oe    = 1'b0;
        mar_load = 1'b0;
        ram_oe   = 1'b0;
        ram_we   = 1'b0;
        ir_load  = 1'b0;
        ir_oe    = 1'b0;
        a_load   = 1'b0;
        a_oe     = 1'b0;
        b_load   = 1'b0;
        alu_sub  = 1'b0;
        alu_oe   = 1'b0;
        out_load = 1'b0;
        if (!reset) begin
            case (state_q)
                S_F0: begin
                    pc_oe    = 1'b1;
                    mar_load = 1'b1;
                end
                S_F2: begin
                    ram_oe  = 1'b1;
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                end
                S_E0: begin
                    case (opcode_q)
                        OP_LDI: begin
                            ir_oe  = 1'b1;
                            a_load = 1'b1;
                        end
                        OP_LDA, OP_STA, OP_ADD, OP_SUB: begin
                            ir_oe    = 1'b1;
                            mar_load = 1'b1;
                        end
                        OP_JMP: begin
                            ir_oe   = 1'b1;
                            pc_load = 1'b1;
                        end
                        OP_JC: begin
                            ir_oe   = flag_carry;
                            pc_load = flag_carry;
                        end
                        OP_JZ: begin
                            ir_oe   = flag_zero;
                            pc_load = flag_zero;
                        end
                        OP_OUT: begin
                            a_oe     = 1'b1;
                            out_load = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_E2: begin
                    case (opcode_q)
                        OP_LDA: begin
                            ram_oe = 1'b1;
                            a_load = 1'b1;
                        end
                        OP_STA: begin
                            a_oe   = 1'b1;
                            ram_we = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_oe = 1'b1;
                            b_load = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_E3: begin
                    if (opcode_q == OP_ADD || opcode_q == OP_SUB) begin
                        alu_oe  = 1'b1;
                        a_load  = 1'b1;
                        alu_sub = (opcode_q == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign halt    = (state_q == S_HALT);
    assign illegal = illegal_q;
    assign t_step  = t_step_q;

    a_one_bus_driver: assert property (@(posedge clk) disable iff (reset)
        $onehot0({pc_oe, ram_oe, ir_oe, a_oe, alu_oe}));

    a_exec_entry_step: assert property (@(posedge clk) disable iff (reset)
        (state_q == S_E0) |-> (t_step_q == T_WIDTH'(FETCH_STEPS)));

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expected strobe/halt/t_step vectors.
// Honors CONTROL_ILLEGAL_TRAP_EN the same way the design does.
module tb_control_sequencer;

    logic       clk;
    logic       reset;
    logic [3:0] opcode;
    logic       flag_zero;
    logic       flag_carry;
    logic       pc_inc, pc_load, pc_oe, mar_load, ram_oe, ram_we, ir_load, ir_oe;
    logic       a_load, a_oe, b_load, alu_sub, alu_oe, out_load, halt, illegal;
    logic [3:0] t_step;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [15:0] M_NONE     = 16'h0000;
    localparam logic [15:0] M_PC_INC   = 16'h0001;
    localparam logic [15:0] M_PC_LOAD  = 16'h0002;
    localparam logic [15:0] M_PC_OE    = 16'h0004;
    localparam logic [15:0] M_MAR_LOAD = 16'h0008;
    localparam logic [15:0] M_RAM_OE   = 16'h0010;
    localparam logic [15:0] M_RAM_WE   = 16'h0020;
    localparam logic [15:0] M_IR_LOAD  = 16'h0040;
    localparam logic [15:0] M_IR_OE    = 16'h0080;
    localparam logic [15:0] M_A_LOAD   = 16'h0100;
    localparam logic [15:0] M_A_OE     = 16'h0200;
    localparam logic [15:0] M_B_LOAD   = 16'h0400;
    localparam logic [15:0] M_ALU_SUB  = 16'h0800;
    localparam logic [15:0] M_ALU_OE   = 16'h1000;
    localparam logic [15:0] M_OUT_LOAD = 16'h2000;
    localparam logic [15:0] M_HALT     = 16'h4000;
    localparam logic [15:0] M_ILLEGAL  = 16'h8000;

    logic [19:0] exp_q[$];
    string       tag_q[$];
    int          checks;
    int          failures;
    logic [19:0] act;

    control_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .pc_inc     (pc_inc),
        .pc_load    (pc_load),
        .pc_oe      (pc_oe),
        .mar_load   (mar_load),
        .ram_oe     (ram_oe),
        .ram_we     (ram_we),
        .ir_load    (ir_load),
        .ir_oe      (ir_oe),
        .a_load     (a_load),
        .a_oe       (a_oe),
        .b_load     (b_load),
        .alu_sub    (alu_sub),
        .alu_oe     (alu_oe),
        .out_load   (out_load),
        .halt       (halt),
        .illegal    (illegal),
        .t_step     (t_step)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign act = {t_step, illegal, halt, out_load, alu_oe, alu_sub, b_load, a_oe, a_load,
                  ir_oe, ir_load, ram_we, ram_oe, mar_load, pc_oe, pc_load, pc_inc};

    function automatic logic [19:0] mk(input logic [15:0] m, input int t);
        int ts;
        ts = (t > 15) ? 15 : t;
        return {4'(ts), m};
    endfunction

    // One clock cycle whose outputs the monitor must match against e.
    task automatic cyc(input logic [19:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic skip_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        skip_cyc();
        cyc(mk(M_NONE, 0), "reset_a");
        cyc(mk(M_NONE, 0), "reset_b");
        reset = 1'b0;
    endtask

    task automatic fetch(input logic [3:0] op, input string name);
        opcode = op;
        cyc(mk(M_PC_OE | M_MAR_LOAD, 0), {name, "/F0"});
        cyc(mk(M_NONE, 1), {name, "/F1"});
        cyc(mk(M_RAM_OE | M_IR_LOAD | M_PC_INC, 2), {name, "/F2"});
        cyc(mk(M_NONE, 3), {name, "/F3"});
        cyc(mk(M_NONE, 4), {name, "/F4"});
        opcode = ~op;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic taken, input string name);
        logic [15:0] ex[$];
        ex = {};
        case (op)
            OP_LDI: begin
                ex.push_back(M_IR_OE | M_A_LOAD);
                ex.push_back(M_NONE);
            end
            OP_LDA: begin
                ex.push_back(M_IR_OE | M_MAR_LOAD);
                ex.push_back(M_NONE);
                ex.push_back(M_RAM_OE | M_A_LOAD);
                ex.push_back(M_NONE);
            end
            OP_STA: begin
                ex.push_back(M_IR_OE | M_MAR_LOAD);
                ex.push_back(M_NONE);
                ex.push_back(M_A_OE | M_RAM_WE);
                ex.push_back(M_NONE);
            end
            OP_ADD: begin
                ex.push_back(M_IR_OE | M_MAR_LOAD);
                ex.push_back(M_NONE);
                ex.push_back(M_RAM_OE | M_B_LOAD);
                ex.push_back(M_ALU_OE | M_A_LOAD);
                ex.push_back(M_NONE);
            end
            OP_SUB: begin
                ex.push_back(M_IR_OE | M_MAR_LOAD);
                ex.push_back(M_NONE);
                ex.push_back(M_RAM_OE | M_B_LOAD);
                ex.push_back(M_ALU_OE | M_A_LOAD | M_ALU_SUB);
                ex.push_back(M_NONE);
            end
            OP_JMP: begin
                ex.push_back(M_IR_OE | M_PC_LOAD);
                ex.push_back(M_NONE);
            end
            OP_JC, OP_JZ: begin
                ex.push_back(taken ? (M_IR_OE | M_PC_LOAD) : M_NONE);
                ex.push_back(M_NONE);
            end
            OP_OUT: begin
                ex.push_back(M_A_OE | M_OUT_LOAD);
                ex.push_back(M_NONE);
            end
            default: ex.push_back(M_NONE);
        endcase
        fetch(op, name);
        foreach (ex[i]) cyc(mk(ex[i], 5 + i), $sformatf("%s/E%0d", name, i));
    endtask

    task automatic run_halted(input logic [3:0] op, input logic [15:0] m, input int n,
                              input string name);
        fetch(op, name);
        for (int k = 0; k < n; k++) cyc(mk(m, 5 + k), $sformatf("%s/H%0d", name, k));
    endtask

    // Monitor: pop one expectation per presented cycle and compare.
    initial begin
        logic [19:0] e;
        string       tag;
        forever begin
            @(negedge clk);
            if (!reset) begin
                checks++;
                if (!$onehot0({pc_oe, ram_oe, ir_oe, a_oe, alu_oe})) begin
                    failures++;
                    $display("FAIL bus_conflict t=%0t oe=%b required onehot0", $time,
                             {pc_oe, ram_oe, ir_oe, a_oe, alu_oe});
                end
            end
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                tag = tag_q.pop_front();
                checks++;
                if (act !== e) begin
                    failures++;
                    $display("FAIL %s: got t=%0d strobes=%h, expected t=%0d strobes=%h",
                             tag, act[19:16], act[15:0], e[19:16], e[15:0]);
                end
            end
        end
    end

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        opcode     = OP_NOP;
        flag_zero  = 1'b0;
        flag_carry = 1'b0;
        do_reset();

        run_instr(OP_LDI, 1'b0, "LDI");
        run_instr(OP_STA, 1'b0, "STA");
        run_instr(OP_LDA, 1'b0, "LDA");
        run_instr(OP_ADD, 1'b0, "ADD");
        run_instr(OP_SUB, 1'b0, "SUB");
        run_instr(OP_JMP, 1'b0, "JMP");
        flag_zero  = 1'b0;
        flag_carry = 1'b1;
        run_instr(OP_JZ, 1'b0, "JZ_nt");
        flag_zero  = 1'b1;
        flag_carry = 1'b0;
        run_instr(OP_JZ, 1'b1, "JZ_t");
        run_instr(OP_JC, 1'b0, "JC_nt");
        flag_zero  = 1'b0;
        flag_carry = 1'b1;
        run_instr(OP_JC, 1'b1, "JC_t");
        flag_carry = 1'b0;
        run_instr(OP_OUT, 1'b0, "OUT");
        run_instr(OP_NOP, 1'b0, "NOP");

`ifdef CONTROL_ILLEGAL_TRAP_EN
        run_halted(4'hA, M_HALT | M_ILLEGAL, 6, "ILL");
        do_reset();
`else
        run_instr(4'hA, 1'b0, "ILL");
`endif

        run_halted(OP_HLT, M_HALT, 20, "HLT");
        do_reset();
        run_instr(OP_LDI, 1'b0, "LDI_post");

        skip_cyc();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
